// File: rtl/pwm_bank_pkg.sv
// Shared register map, CTRL/STATUS bit positions and the CTRL register type for avalon_pwm_bank.
package pwm_bank_pkg;

    localparam int unsigned REG_CTRL      = 0;
    localparam int unsigned REG_PERIOD    = 1;
    localparam int unsigned REG_PRESCALE  = 2;
    localparam int unsigned REG_STATUS    = 3;
    localparam int unsigned REG_DUTY_BASE = 4;

    localparam int unsigned CTRL_EN_BIT         = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT     = 1;
    localparam int unsigned STATUS_IRQ_PEND_BIT = 31;

    typedef struct packed {
        logic irq_en;
        logic en;
    } ctrl_t;

    function automatic logic [31:0] ctrl_to_word(ctrl_t c);
        logic [31:0] word;
        word                  = '0;
        word[CTRL_EN_BIT]     = c.en;
        word[CTRL_IRQ_EN_BIT] = c.irq_en;
        return word;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler feeding a period counter; held at zero while disabled.
module pwm_timebase #(
    parameter int unsigned CNT_W   = 20,
    parameter int unsigned PRESC_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic [PRESC_W-1:0] presc,
    input  logic [CNT_W-1:0]   period,
    output logic [CNT_W-1:0]   cnt,
    output logic               tick,
    output logic               wrap
);

    logic [PRESC_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_comb begin
        tick   = en && (pcnt_q == presc);
        wrap   = tick && (cnt_q == period);
        pcnt_d = pcnt_q;
        cnt_d  = cnt_q;
        if (!en) begin
            pcnt_d = '0;
            cnt_d  = '0;
        end else if (tick) begin
            pcnt_d = '0;
            cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
        end else begin
            pcnt_d = pcnt_q + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt_q <= '0;
            cnt_q  <= '0;
        end else begin
            pcnt_q <= pcnt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/avalon_pwm_bank.sv
// Avalon-MM PWM bank: double-buffered PERIOD/PRESCALE/DUTY registers, shared timebase and
// NUM_CH registered comparators. Optional irq output enabled by defining PWM_IRQ_EN.
module avalon_pwm_bank
    import pwm_bank_pkg::*;
#(
    parameter int unsigned  NUM_CH  = 20,
    parameter int unsigned  CNT_W   = 20,
    parameter int unsigned  PRESC_W = 16,
    localparam int unsigned ADDR_W  = $clog2(NUM_CH + 4)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic [NUM_CH-1:0] pwm_out
`ifdef PWM_IRQ_EN
    ,
    output logic              irq
`endif
);

    ctrl_t              ctrl_q, ctrl_d;
    logic [CNT_W-1:0]   period_pend_q, period_pend_d, period_act_q;
    logic [PRESC_W-1:0] presc_pend_q, presc_pend_d, presc_act_q;
    logic [CNT_W-1:0]   duty_pend_q [NUM_CH];
    logic [CNT_W-1:0]   duty_pend_d [NUM_CH];
    logic [CNT_W-1:0]   duty_act_q  [NUM_CH];
    logic               irq_pend_q, irq_pend_d;
    logic [31:0]        rd_word, readdata_q;
    logic [NUM_CH-1:0]  pwm_q, pwm_d;
    logic [CNT_W-1:0]   cnt;
    logic               wrap, load_act;
    logic               unused_tick, unused_wdata;
    int unsigned        addr_idx;

    assign addr_idx     = 32'(avs_address);
    assign unused_wdata = ^avs_writedata;

    pwm_timebase #(
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W)
    ) u_timebase (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (ctrl_q.en),
        .presc   (presc_act_q),
        .period  (period_act_q),
        .cnt     (cnt),
        .tick    (unused_tick),
        .wrap    (wrap)
    );

    // Active copies track pending while idle so enabling starts from the current settings.
    assign load_act = !ctrl_q.en || wrap;

    always_comb begin
        ctrl_d        = ctrl_q;
        period_pend_d = period_pend_q;
        presc_pend_d  = presc_pend_q;
        duty_pend_d   = duty_pend_q;
        irq_pend_d    = irq_pend_q;
        if (avs_write) begin
            if (addr_idx == REG_CTRL) begin
                ctrl_d.en = avs_writedata[CTRL_EN_BIT];
`ifdef PWM_IRQ_EN
                ctrl_d.irq_en = avs_writedata[CTRL_IRQ_EN_BIT];
`endif
            end
            if (addr_idx == REG_PERIOD) begin
                period_pend_d = avs_writedata[CNT_W-1:0];
            end
            if (addr_idx == REG_PRESCALE) begin
                presc_pend_d = avs_writedata[PRESC_W-1:0];
            end
            if (addr_idx == REG_STATUS && avs_writedata[STATUS_IRQ_PEND_BIT]) begin
                irq_pend_d = 1'b0;
            end
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (addr_idx == REG_DUTY_BASE + k) begin
                    duty_pend_d[k] = avs_writedata[CNT_W-1:0];
                end
            end
        end
        // A wrap beats a coincident write-1-to-clear.
        if (wrap) begin
            irq_pend_d = 1'b1;
        end
`ifndef PWM_IRQ_EN
        ctrl_d.irq_en = 1'b0;
`endif
    end

    always_comb begin
        rd_word = '0;
        case (addr_idx)
            REG_CTRL:     rd_word = ctrl_to_word(ctrl_q);
            REG_PERIOD:   rd_word = 32'(period_pend_q);
            REG_PRESCALE: rd_word = 32'(presc_pend_q);
            REG_STATUS: begin
                rd_word                      = 32'(cnt);
                rd_word[STATUS_IRQ_PEND_BIT] = irq_pend_q;
            end
            default: begin
                for (int unsigned k = 0; k < NUM_CH; k++) begin
                    if (addr_idx == REG_DUTY_BASE + k) begin
                        rd_word = 32'(duty_pend_q[k]);
                    end
                end
            end
        endcase
    end

    always_comb begin
        pwm_d = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            pwm_d[k] = ctrl_q.en && (cnt < duty_act_q[k]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q        <= '0;
            period_pend_q <= '0;
            presc_pend_q  <= '0;
            duty_pend_q   <= '{default: '0};
            period_act_q  <= '0;
            presc_act_q   <= '0;
            duty_act_q    <= '{default: '0};
            irq_pend_q    <= 1'b0;
            readdata_q    <= '0;
            pwm_q         <= '0;
        end else begin
            ctrl_q        <= ctrl_d;
            period_pend_q <= period_pend_d;
            presc_pend_q  <= presc_pend_d;
            duty_pend_q   <= duty_pend_d;
            irq_pend_q    <= irq_pend_d;
            pwm_q         <= pwm_d;
            if (load_act) begin
                period_act_q <= period_pend_q;
                presc_act_q  <= presc_pend_q;
                duty_act_q   <= duty_pend_q;
            end
            if (avs_read) begin
                readdata_q <= rd_word;
            end
        end
    end

    assign avs_readdata = readdata_q;
    assign pwm_out      = pwm_q;

`ifdef PWM_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_pend_q & ctrl_q.irq_en;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_avalon_pwm_bank.sv
// Self-checking bench for avalon_pwm_bank: directed scenarios plus random bus traffic checked
// cycle by cycle against a period/phase arithmetic model.
module tb_avalon_pwm_bank;

    localparam int NUM_CH  = 5;
    localparam int CNT_W   = 12;
    localparam int PRESC_W = 8;
    localparam int ADDR_W  = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic [31:0]       avs_readdata;
    logic [NUM_CH-1:0] pwm_out;
`ifdef PWM_IRQ_EN
    logic              irq;
`endif

    always #5 clk = ~clk;

    avalon_pwm_bank #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .pwm_out       (pwm_out)
`ifdef PWM_IRQ_EN
        ,
        .irq           (irq)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: position within the period in clocks; count = phase / (PRESCALE+1).
    bit          m_en, m_irq_en, m_pend;
    int unsigned m_period_p, m_presc_p, m_period_a, m_presc_a, m_phase;
    int unsigned m_duty_p [NUM_CH];
    int unsigned m_duty_a [NUM_CH];
    logic [NUM_CH-1:0] exp_pwm;
    logic [31:0]       exp_rd;
    bit                exp_irq;

    function automatic int unsigned m_count();
        return m_phase / (m_presc_a + 1);
    endfunction

    function automatic bit m_wrap_now();
        return m_en && (m_phase == (m_period_a + 1) * (m_presc_a + 1) - 1);
    endfunction

    task automatic model_reset();
        m_en = 0; m_irq_en = 0; m_pend = 0;
        m_period_p = 0; m_presc_p = 0; m_period_a = 0; m_presc_a = 0; m_phase = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            m_duty_p[k] = 0;
            m_duty_a[k] = 0;
        end
        exp_pwm = '0; exp_rd = '0; exp_irq = 0;
    endtask

    task automatic model_step();
        bit          wrap;
        int unsigned cnt;
        int          a;
        logic [31:0] wd;
        wrap = m_wrap_now();
        cnt  = m_count();
        a    = int'(avs_address);
        wd   = avs_writedata;
        for (int k = 0; k < NUM_CH; k++) exp_pwm[k] = m_en && (cnt < m_duty_a[k]);
        exp_irq = m_pend && m_irq_en;
        if (avs_read) begin
            exp_rd = '0;
            if (a == 0) exp_rd = {30'b0, m_irq_en, m_en};
            else if (a == 1) exp_rd = m_period_p;
            else if (a == 2) exp_rd = m_presc_p;
            else if (a == 3) begin
                exp_rd     = cnt;
                exp_rd[31] = m_pend;
            end else if (a < 4 + NUM_CH) exp_rd = m_duty_p[a-4];
        end
        if (!m_en || wrap) m_phase = 0;
        else m_phase = m_phase + 1;
        if (!m_en || wrap) begin
            m_period_a = m_period_p;
            m_presc_a  = m_presc_p;
            for (int k = 0; k < NUM_CH; k++) m_duty_a[k] = m_duty_p[k];
        end
        if (wrap) m_pend = 1;
        else if (avs_write && a == 3 && wd[31]) m_pend = 0;
        if (avs_write) begin
            if (a == 0) begin
                m_en = wd[0];
`ifdef PWM_IRQ_EN
                m_irq_en = wd[1];
`endif
            end else if (a == 1) m_period_p = 32'(wd[CNT_W-1:0]);
            else if (a == 2) m_presc_p = 32'(wd[PRESC_W-1:0]);
            else if (a >= 4 && a < 4 + NUM_CH) m_duty_p[a-4] = 32'(wd[CNT_W-1:0]);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_eq("pwm", 32'(pwm_out), 32'(exp_pwm));
        check_eq("readdata", avs_readdata, exp_rd);
`ifdef PWM_IRQ_EN
        check_eq("irq", 32'(irq), 32'(exp_irq));
`endif
    endtask

    task automatic bus_write(input int a, input logic [31:0] d);
        avs_write = 1'b1; avs_address = ADDR_W'(a); avs_writedata = d;
        cyc();
        avs_write = 1'b0;
    endtask

    task automatic bus_read(input int a, output logic [31:0] d);
        avs_read = 1'b1; avs_address = ADDR_W'(a);
        cyc();
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    // Runs through the next wrap cycle (inclusive).
    task automatic run_to_wrap();
        bit w;
        int guard;
        guard = 0;
        do begin
            w = m_wrap_now();
            cyc();
            guard++;
        end while (!w && guard < 200);
        check_eq("wrap_seen", 32'(w), 32'd1);
    endtask

    // Stops just before a wrap cycle, so the next bus access lands in it.
    task automatic run_until_wrap_next();
        int guard;
        guard = 0;
        while (!m_wrap_now() && guard < 200) begin
            cyc();
            guard++;
        end
        check_eq("wrap_found", 32'(m_wrap_now()), 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        int          highs, highs1, highs2, highs3;

        reset_n = 1'b0; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_pwm", 32'(pwm_out), 32'd0);
        check_eq("rst_readdata", avs_readdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int a = 0; a < 16; a++) begin
            bus_read(a, d);
            check_eq("reset_rd", d, 32'd0);
        end

        // 10-clock period, 3 high.
        bus_write(1, 32'd9);
        bus_write(2, 32'd0);
        bus_write(4, 32'd3);
        bus_write(0, 32'd1);
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (i == 0) check_eq("first_high", 32'(pwm_out[0]), 32'd1);
            highs += int'(pwm_out[0]);
        end
        check_eq("duty3_highs", 32'(highs), 32'd6);

        // Mid-period update takes effect only after the wrap.
        bus_write(4, 32'd7);
        bus_write(1, 32'd4);
        run_to_wrap();
        highs = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            highs += int'(pwm_out[0]);
        end
        check_eq("duty_gt_period_highs", 32'(highs), 32'd10);

        // Boundary duties with prescaling: 12-clock period.
        bus_write(5, 32'd0);
        bus_write(6, 32'd4);
        bus_write(7, 32'd2);
        bus_write(2, 32'd2);
        bus_write(1, 32'd3);
        run_to_wrap();
        cyc();
        highs1 = 0; highs2 = 0; highs3 = 0;
        for (int i = 0; i < 24; i++) begin
            bus_read(3, d);
            highs1 += int'(pwm_out[1]);
            highs2 += int'(pwm_out[2]);
            highs3 += int'(pwm_out[3]);
        end
        check_eq("duty0_low", 32'(highs1), 32'd0);
        check_eq("duty_p1_high", 32'(highs2), 32'd24);
        check_eq("duty2_presc_highs", 32'(highs3), 32'd12);

        // DUTY write landing in the wrap cycle is deferred one period.
        run_until_wrap_next();
        bus_write(7, 32'd11);
        highs = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            highs += int'(pwm_out[3]);
        end
        check_eq("wrap_write_old", 32'(highs), 32'd6);
        highs = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            highs += int'(pwm_out[3]);
        end
        check_eq("wrap_write_new", 32'(highs), 32'd12);

        // Interrupt pending and W1C.
        bus_write(0, 32'd3);
        bus_write(3, 32'h8000_0000);
        run_to_wrap();
        cyc();
`ifdef PWM_IRQ_EN
        check_eq("irq_after_wrap", 32'(irq), 32'd1);
`endif
        bus_read(3, d);
        check_eq("pend_set", 32'(d[31]), 32'd1);
        bus_write(3, 32'h8000_0000);
        cyc();
        bus_read(3, d);
        check_eq("pend_cleared", 32'(d[31]), 32'd0);
`ifdef PWM_IRQ_EN
        check_eq("irq_cleared", 32'(irq), 32'd0);
`endif
        run_until_wrap_next();
        bus_write(3, 32'h8000_0000);
        cyc();
        bus_read(3, d);
        check_eq("set_wins", 32'(d[31]), 32'd1);
`ifdef PWM_IRQ_EN
        check_eq("irq_set_wins", 32'(irq), 32'd1);
`endif

        // Disable mid-period.
        if (m_wrap_now()) cyc();
        bus_write(0, 32'd0);
        cyc();
        check_eq("disable_pwm", 32'(pwm_out), 32'd0);
        bus_read(3, d);
        check_eq("disable_cnt", 32'(d[CNT_W-1:0]), 32'd0);

        // Random traffic.
        bus_write(0, 32'd1);
        for (int i = 0; i < 3000; i++) begin
            int r, sel;
            r = $urandom_range(0, 99);
            if (r < 8) begin
                sel = $urandom_range(0, 4);
                case (sel)
                    0: bus_write(0, ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 3)));
                    1: bus_write(1, ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 7)));
                    2: bus_write(2, ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 3)));
                    3: bus_write(3, $urandom);
                    default: bus_write(4 + $urandom_range(0, NUM_CH - 1),
                                       32'($urandom_range(0, 9)));
                endcase
            end else if (r < 30) begin
                bus_read($urandom_range(0, 15), d);
            end else begin
                cyc();
            end
        end

        // Asynchronous reset mid-period.
        bus_write(0, 32'd3);
        repeat (5) cyc();
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_rst_pwm", 32'(pwm_out), 32'd0);
        check_eq("async_rst_rd", avs_readdata, 32'd0);
`ifdef PWM_IRQ_EN
        check_eq("async_rst_irq", 32'(irq), 32'd0);
`endif
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 16; a++) begin
            bus_read(a, d);
            check_eq("post_rst_rd", d, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/avalon_pwm_bank.md
Name: avalon_pwm_bank

Overview:
- Multi-channel, memory-mapped PWM generator on the HPS lightweight Avalon-MM bridge.
- Parametrised successor to the fixed 20-bit custom LED output: one shared, prescaled period counter drives NUM_CH independent duty comparators.
- Duty and period registers are double-buffered, so software updates take effect only at a period boundary (glitch-free servo/LED control).
- Exported PWM lines go to the top level as a conduit.

Parameters:
- NUM_CH, 20, number of PWM output channels (1..28).
- CNT_W, 20, width of period counter, PERIOD and DUTY registers (<=32).
- PRESC_W, 16, width of prescaler counter and PRESCALE register (<=32).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- avs_address  input  ADDR_W  word address; ADDR_W = clog2(NUM_CH+4), a derived localparam.
- avs_read  input  1  read strobe.
- avs_write  input  1  write strobe.
- avs_writedata  input  32  write data.
- avs_readdata  output  32  read data, valid one cycle after avs_read.
- pwm_out  output  NUM_CH  registered PWM outputs.
- irq  output  1  period-wrap interrupt; present only with PWM_IRQ_EN.

Behaviour:
- Register map (word offsets):
  - 0 CTRL: bit0 EN, bit1 IRQ_EN.
  - 1 PERIOD.
  - 2 PRESCALE.
  - 3 STATUS: [CNT_W-1:0] current count, read-only; bit31 IRQ_PEND, write-1-to-clear.
  - 4+k DUTY[k], k = 0..NUM_CH-1.
- No waitrequest: writes complete in the strobe cycle; read latency is 1 cycle.
- Reads of unmapped addresses return 0. Unused upper bits read 0; writes to them are ignored.
- PERIOD, PRESCALE and DUTY reads return the pending (software) value, not the active value.
- Reset values:
  - All registers, counters, pending and active copies = 0.
  - pwm_out = 0, avs_readdata = 0, irq = 0.
- Prescaler:
  - pcnt counts 0..presc_act; tick asserts in the cycle pcnt == presc_act, then pcnt <= 0.
  - PRESCALE = 0 gives a tick every cycle.
- Period counter:
  - On each tick: if cnt == period_act, then cnt <= 0 and wrap asserts for that cycle; otherwise cnt <= cnt+1.
  - Period length = (PERIOD+1)*(PRESCALE+1) clocks.
- Shadow load:
  - On a wrap cycle, period_act, presc_act and duty_act[k] <= pending values as held at the start of that cycle.
  - A register write in the same cycle as wrap lands in pending and is applied at the next wrap.
- Compare:
  - pwm_out[k] <= EN & (cnt < duty_act[k]); registered, one cycle after the counter value.
  - DUTY = 0 gives constant low.
  - DUTY > PERIOD gives constant high.
  - Comparison is unsigned, CNT_W bits wide.
- Disable (EN = 0):
  - pcnt and cnt are held at 0; wrap never asserts.
  - Active copies follow pending every cycle.
  - pwm_out goes to 0 on the next clock.
- EN 0->1: counting starts from cnt = 0, pcnt = 0 with the current pending values. The first pwm_out high (if DUTY > 0) appears 1 cycle after the EN write cycle.
- IRQ_PEND:
  - Set on wrap.
  - A W1C write clears it; if the clear coincides with wrap, set wins.
- Reset asserted mid-period: everything returns to reset values immediately (asynchronous). Reset deassertion is assumed synchronised externally.

Optional Feature:
- Macro: PWM_IRQ_EN.
- Defined: irq port exists; irq = IRQ_PEND & CTRL.IRQ_EN, registered.
- Undefined: irq port and CTRL.IRQ_EN are absent; CTRL bit1 reads 0. STATUS bit31 still reports wraps and remains W1C.

Decomposition:
- Package pwm_bank_pkg holds:
  - Register offset constants REG_CTRL, REG_PERIOD, REG_PRESCALE, REG_STATUS, REG_DUTY_BASE.
  - CTRL/STATUS bit-position constants.
  - A typedef for the CTRL register struct.
- Sub-module pwm_timebase: prescaler plus period counter, producing cnt, tick and wrap. The comparators and register file stay in the top module.

Test Plan:
- Reset, then read all addresses 0..NUM_CH+3 -> all return 0; pwm_out = 0.
- PERIOD = 9, PRESCALE = 0, DUTY[0] = 3, EN = 1 -> pwm_out[0] high 3 clocks, low 7, repeating every 10 clocks; first high 1 cycle after the EN write.
- While running: write DUTY[0] = 7, then PERIOD = 4, mid-period -> the current period completes unchanged; the next period is 5 clocks with the output constantly high (7 > 4).
- Boundary values: DUTY[1] = 0, DUTY[2] = PERIOD+1, PRESCALE = 2, PERIOD = 3 -> ch1 constant low; ch2 constant high; period = 12 clocks; STATUS count steps every 3 clocks.
- Write a DUTY in the exact wrap cycle -> the old value is used for one more period, then the new value applies.
- PWM_IRQ_EN defined, IRQ_EN = 1 -> irq rises 1 cycle after wrap; W1C clears it. A W1C coinciding with wrap leaves irq asserted. Clearing EN mid-period -> pwm_out = 0 next clock and STATUS count = 0.
